// File: rtl/pwm_pulse_decoder.sv
// Servo-style PWM receiver: measures filtered high time in c50m ticks and maps it to a 10-bit duty value.
// Define PWM_DECODE_AVG_EN to report the mean of the last four accepted values instead of the latest one.
module pwm_pulse_decoder #(
  parameter int MIN_TICKS     = 50000,
  parameter int MAX_TICKS     = 100000,
  parameter int SCALE         = 1341,
  parameter int TIMEOUT_TICKS = 1250000,
  parameter int FILTER_LEN    = 4
) (
  input  logic       c50m,
  input  logic       reset,
  input  logic       PWMin,
  output logic [9:0] PWMvalue,
  output logic       PWMvalid,
  output logic       PWMerror,
  output logic       PWMlost
);

  localparam int W_W    = $clog2(2 * MAX_TICKS + 2);
  localparam int P_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam int F_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int D_W    = $clog2(MAX_TICKS - MIN_TICKS + 1);
  localparam int S_W    = $clog2(SCALE + 1);
  localparam int PROD_W = (D_W + S_W > 34) ? D_W + S_W : 34;

  localparam logic [W_W-1:0]    W_HALF_MIN = W_W'(MIN_TICKS / 2);
  localparam logic [W_W-1:0]    W_MIN      = W_W'(MIN_TICKS);
  localparam logic [W_W-1:0]    W_MAX      = W_W'(MAX_TICKS);
  localparam logic [W_W-1:0]    W_REJ      = W_W'(2 * MAX_TICKS);
  localparam logic [W_W-1:0]    W_SAT      = W_W'(2 * MAX_TICKS + 1);
  localparam logic [P_W-1:0]    P_LAST     = P_W'(TIMEOUT_TICKS - 1);
  localparam logic [P_W-1:0]    P_SAT      = P_W'(TIMEOUT_TICKS);
  localparam logic [F_W-1:0]    F_LAST     = F_W'(FILTER_LEN - 1);
  localparam logic [PROD_W-1:0] SCALE_P    = PROD_W'(SCALE);

  typedef enum logic [1:0] {S_ARM, S_LOW, S_HIGH, S_EVAL} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             filt_q, filt_d;
  logic [F_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic [W_W-1:0]   width_q, width_d;
  logic [P_W-1:0]   period_q, period_d;
  logic             s1_ok_q, s1_ok_d;
  logic             s1_err_q, s1_err_d;
  logic             s1_full_q, s1_full_d;
  logic [D_W-1:0]   s1_diff_q, s1_diff_d;
  logic [9:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             lost_q, lost_d;

  logic             rise, fall, loss;
  logic             start, width_inc, eval_en;
  logic [PROD_W-1:0] prod_hi;
  logic [9:0]       scaled;
  logic [9:0]       new_value;

  // Synchronizer and filter come out of reset high, so a pulse already in progress
  // at reset release is seen as high and ARM waits for its end.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sync_d     = {sync_q[0], PWMin};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync_q[1] != filt_q) begin
      if (filt_cnt_q == F_LAST) filt_d = sync_q[1];
      else                      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  // Edges are taken from the filter's next value so EVAL lines up with the first filtered-low cycle.
  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

  always_ff @(posedge c50m or posedge reset) begin
    if (reset) state_q <= S_ARM;
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARM:   if (!filt_q) state_d = S_LOW;
      S_LOW:   if (rise)    state_d = S_HIGH;
      S_HIGH:  if (fall)    state_d = S_EVAL;
      S_EVAL:  state_d = rise ? S_HIGH : S_LOW;
      default: state_d = S_ARM;
    endcase
    if (loss) state_d = S_ARM;
  end

  always_comb begin
    start     = 1'b0;
    width_inc = 1'b0;
    eval_en   = 1'b0;
    case (state_q)
      S_LOW:   start = rise;
      S_HIGH:  width_inc = filt_d;
      S_EVAL:  begin
        eval_en = ~loss;
        start   = rise;
      end
      default: ;
    endcase
  end

  always_comb begin
    width_d = width_q;
    if (start)                             width_d = W_W'(1);
    else if (width_inc && width_q != W_SAT) width_d = width_q + 1'b1;
    period_d = period_q;
    if (start)                 period_d = '0;
    else if (period_q != P_SAT) period_d = period_q + 1'b1;
  end

  // Loss fires once, on the step into saturation; a restart the same cycle pre-empts it.
  assign loss = !start && (period_q == P_LAST);

  always_comb begin
    s1_ok_d   = 1'b0;
    s1_err_d  = 1'b0;
    s1_full_d = 1'b0;
    s1_diff_d = '0;
    if (eval_en) begin
      if (width_q < W_HALF_MIN || width_q > W_REJ) begin
        s1_err_d = 1'b1;
      end else begin
        s1_ok_d   = 1'b1;
        s1_full_d = (width_q > W_MAX);
        if (width_q >= W_MIN && width_q <= W_MAX) s1_diff_d = D_W'(width_q - W_MIN);
      end
    end
  end

  always_comb begin
    prod_hi = (PROD_W'(s1_diff_q) * SCALE_P) >> 16;
    scaled  = (s1_full_q || (|prod_hi[PROD_W-1:10])) ? 10'd1023 : prod_hi[9:0];
  end

`ifdef PWM_DECODE_AVG_EN
  logic [2:0][9:0] hist_q, hist_d;
  logic [11:0]     avg_sum;

  always_comb begin
    avg_sum = 12'(scaled) + 12'(hist_q[0]) + 12'(hist_q[1]) + 12'(hist_q[2]);
    hist_d  = hist_q;
    if (loss)         hist_d = '0;
    else if (valid_d) hist_d = {hist_q[1], hist_q[0], scaled};
  end

  assign new_value = 10'(avg_sum >> 2);

  always_ff @(posedge c50m or posedge reset) begin
    // NOTE: the history is a tiny register file, so it is reset like any other flop to start the mean from zero.
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end
`else
  assign new_value = scaled;
`endif

  always_comb begin
    valid_d = s1_ok_q & ~loss;
    error_d = s1_err_q & ~loss;
    value_d = value_q;
    lost_d  = lost_q;
    if (loss) begin
      value_d = '0;
      lost_d  = 1'b1;
    end else if (valid_d) begin
      value_d = new_value;
      lost_d  = 1'b0;
    end
  end

  always_ff @(posedge c50m or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      width_q    <= '0;
      period_q   <= '0;
      s1_ok_q    <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_full_q  <= 1'b0;
      s1_diff_q  <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      lost_q     <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      width_q    <= width_d;
      period_q   <= period_d;
      s1_ok_q    <= s1_ok_d;
      s1_err_q   <= s1_err_d;
      s1_full_q  <= s1_full_d;
      s1_diff_q  <= s1_diff_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      lost_q     <= lost_d;
    end
  end

  assign PWMvalue = value_q;
  assign PWMvalid = valid_q;
  assign PWMerror = error_q;
  assign PWMlost  = lost_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// Directed bench for pwm_pulse_decoder with scaled-down timing (1 ms = 500 ticks).
// Expected values adapt when PWM_DECODE_AVG_EN is defined.
module tb_pwm_pulse_decoder;

  localparam int MIN_T   = 500;
  localparam int MAX_T   = 1000;
  localparam int SCALE_T = 134087;
  localparam int TO_T    = 2500;
  localparam int FL      = 4;
  localparam int LAT     = 2 + FL + 2;
  localparam int LOSS_LAT = TO_T + 2 + FL;

  logic       c50m = 1'b0;
  logic       reset;
  logic       PWMin;
  logic [9:0] PWMvalue;
  logic       PWMvalid;
  logic       PWMerror;
  logic       PWMlost;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_strobe_cyc = 0;
  int rise_cyc = 0;
  logic lost_at_valid = 1'b1;

`ifdef PWM_DECODE_AVG_EN
  logic [9:0] hist [4];
`endif

  pwm_pulse_decoder #(
    .MIN_TICKS    (MIN_T),
    .MAX_TICKS    (MAX_T),
    .SCALE        (SCALE_T),
    .TIMEOUT_TICKS(TO_T),
    .FILTER_LEN   (FL)
  ) dut (
    .c50m    (c50m),
    .reset   (reset),
    .PWMin   (PWMin),
    .PWMvalue(PWMvalue),
    .PWMvalid(PWMvalid),
    .PWMerror(PWMerror),
    .PWMlost (PWMlost)
  );

  always #10 c50m = ~c50m;

  always @(posedge c50m) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge c50m) begin
    if (PWMvalid || PWMerror) check("strobe_exclusive", 32'(PWMvalid & PWMerror), 32'd0);
    if (PWMvalid) begin
      n_valid++;
      last_strobe_cyc = cyc;
      lost_at_valid   = PWMlost;
    end
    if (PWMerror) begin
      n_err++;
      last_strobe_cyc = cyc;
    end
  end

  task automatic model_clear;
`ifdef PWM_DECODE_AVG_EN
    for (int i = 0; i < 4; i++) hist[i] = '0;
`endif
  endtask

  task automatic model_push(input logic [9:0] v, output logic [9:0] o);
`ifdef PWM_DECODE_AVG_EN
    logic [11:0] sum;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = v;
    sum = 12'(hist[0]) + 12'(hist[1]) + 12'(hist[2]) + 12'(hist[3]);
    o = 10'(sum >> 2);
`else
    o = v;
`endif
  endtask

  // One pulse of `hi` ticks inside a `per`-tick period; called just after a negedge.
  task automatic do_pulse(input string tag, input int hi, input int per,
                          input bit accept, input logic [9:0] new_val);
    int v0, e0, fall_cyc;
    logic [9:0] held, exp_v;
    logic lost0;
    v0 = n_valid; e0 = n_err; held = PWMvalue; lost0 = PWMlost;
    PWMin = 1'b1; rise_cyc = cyc;
    repeat (hi) @(negedge c50m);
    PWMin = 1'b0; fall_cyc = cyc;
    repeat (per - hi) @(negedge c50m);
    if (accept) begin
      model_push(new_val, exp_v);
      check({tag, " valid_count"}, n_valid - v0, 1);
      check({tag, " error_count"}, n_err - e0, 0);
      check({tag, " value"}, 32'(PWMvalue), 32'(exp_v));
      check({tag, " lost_at_valid"}, 32'(lost_at_valid), 32'd0);
    end else begin
      check({tag, " valid_count"}, n_valid - v0, 0);
      check({tag, " error_count"}, n_err - e0, 1);
      check({tag, " value_held"}, 32'(PWMvalue), 32'(held));
      check({tag, " lost_held"}, 32'(PWMlost), 32'(lost0));
    end
    check({tag, " latency"}, last_strobe_cyc - fall_cyc, LAT);
  endtask

  initial begin
    int v0, e0, fall_cyc;
    logic [9:0] exp_v;

    model_clear();
    reset = 1'b1;
    PWMin = 1'b0;
    repeat (5) @(negedge c50m);
    check("reset value", 32'(PWMvalue), 32'd0);
    check("reset valid", 32'(PWMvalid), 32'd0);
    check("reset error", 32'(PWMerror), 32'd0);
    check("reset lost", 32'(PWMlost), 32'd1);
    reset = 1'b0;
    repeat (20) @(negedge c50m);

    do_pulse("p1500us_first", 750, 2000, 1'b1, 10'd511);
    do_pulse("p1500us_second", 750, 2000, 1'b1, 10'd511);
    do_pulse("p1000us", 500, 2000, 1'b1, 10'd0);
    do_pulse("p2000us", 1000, 2000, 1'b1, 10'd1023);
    do_pulse("p800us_clamp", 400, 2000, 1'b1, 10'd0);
    do_pulse("p3000us_clamp", 1500, 2000, 1'b1, 10'd1023);
    do_pulse("p1200us", 600, 2000, 1'b1, 10'd204);
    do_pulse("p1800us", 900, 2000, 1'b1, 10'd818);
    do_pulse("w_half_min", 250, 2000, 1'b1, 10'd0);
    do_pulse("w_below_half_min", 249, 2000, 1'b0, 10'd0);
    do_pulse("w_max_plus1", 1001, 2000, 1'b1, 10'd1023);
    do_pulse("w_twice_max", 2000, 2400, 1'b1, 10'd1023);
    do_pulse("w_over_twice_max", 2100, 2400, 1'b0, 10'd0);
    do_pulse("p1500us_before_short", 750, 2000, 1'b1, 10'd511);
    do_pulse("p300us_reject", 150, 2000, 1'b0, 10'd0);

    v0 = n_valid; e0 = n_err;
    repeat (5) begin
      PWMin = 1'b1;
      repeat (2) @(negedge c50m);
      PWMin = 1'b0;
      repeat (20) @(negedge c50m);
    end
    check("glitch valid_count", n_valid - v0, 0);
    check("glitch error_count", n_err - e0, 0);

    v0 = n_valid;
    PWMin = 1'b1; rise_cyc = cyc;
    repeat (300) @(negedge c50m);
    PWMin = 1'b0;
    repeat (3) @(negedge c50m);
    PWMin = 1'b1;
    repeat (447) @(negedge c50m);
    PWMin = 1'b0; fall_cyc = cyc;
    repeat (1250) @(negedge c50m);
    model_push(10'd511, exp_v);
    check("dropout valid_count", n_valid - v0, 1);
    check("dropout value", 32'(PWMvalue), 32'(exp_v));
    check("dropout latency", last_strobe_cyc - fall_cyc, LAT);

    v0 = n_valid;
    for (int i = 0; i < 1000 && !PWMlost; i++) @(negedge c50m);
    check("loss delay", cyc - rise_cyc, LOSS_LAT);
    check("loss lost", 32'(PWMlost), 32'd1);
    check("loss value", 32'(PWMvalue), 32'd0);
    check("loss valid_count", n_valid - v0, 0);
    model_clear();
    repeat (10) @(negedge c50m);
    do_pulse("after_loss", 750, 2000, 1'b1, 10'd511);
    check("after_loss lost", 32'(PWMlost), 32'd0);

    v0 = n_valid; e0 = n_err;
    PWMin = 1'b1;
    repeat (400) @(negedge c50m);
    reset = 1'b1;
    @(negedge c50m);
    check("midpulse reset value", 32'(PWMvalue), 32'd0);
    check("midpulse reset lost", 32'(PWMlost), 32'd1);
    check("midpulse reset valid", 32'(PWMvalid), 32'd0);
    repeat (3) @(negedge c50m);
    reset = 1'b0;
    repeat (400) @(negedge c50m);
    PWMin = 1'b0;
    repeat (1600) @(negedge c50m);
    check("partial valid_count", n_valid - v0, 0);
    check("partial error_count", n_err - e0, 0);
    check("partial lost", 32'(PWMlost), 32'd1);
    model_clear();
    do_pulse("full_after_reset_1", 1000, 2000, 1'b1, 10'd1023);
    do_pulse("full_after_reset_2", 1000, 2000, 1'b1, 10'd1023);
    do_pulse("full_after_reset_3", 1000, 2000, 1'b1, 10'd1023);
    do_pulse("full_after_reset_4", 1000, 2000, 1'b1, 10'd1023);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
